// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time-of-day counters / button debouncers and the
// alarm stage. The master side drives time digits and user pulses; the slave
// side (alarm_ctrl) returns alarm digits, blink enables and status.
interface alarm_ctrl_if;
  // Timing and user controls
  logic       EN1HZ;
  logic       SIG2HZ;
  logic       ARM;
  logic       ALMSET;
  logic       SELECT;
  logic       ADJUST;
  logic       STOP;
  // Running time of day, BCD
  logic [1:0] HOURH;
  logic [3:0] HOURL;
  logic [2:0] MINH;
  logic [3:0] MINL;
  logic [2:0] SECH;
  logic [3:0] SECL;
  // Alarm time and display enables
  logic [1:0] AHOURH;
  logic [3:0] AHOURL;
  logic [2:0] AMINH;
  logic [3:0] AMINL;
  logic       AHOURON;
  logic       AMINON;
  // Status
  logic       EDITING;
  logic       RINGING;
  logic       SNOOZING;
  logic       BUZZ;

  modport master (
    output EN1HZ, SIG2HZ, ARM, ALMSET, SELECT, ADJUST, STOP,
    output HOURH, HOURL, MINH, MINL, SECH, SECL,
    input  AHOURH, AHOURL, AMINH, AMINL, AHOURON, AMINON,
    input  EDITING, RINGING, SNOOZING, BUZZ
  );

  modport slave (
    input  EN1HZ, SIG2HZ, ARM, ALMSET, SELECT, ADJUST, STOP,
    input  HOURH, HOURL, MINH, MINL, SECH, SECL,
    output AHOURH, AHOURL, AMINH, AMINL, AHOURON, AMINON,
    output EDITING, RINGING, SNOOZING, BUZZ
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm stage for the 24-hour clock: editable BCD alarm time, edge-triggered
// ringing with auto-stop, snooze, and blink enables for the alarm digits.
module alarm_ctrl #(
  parameter logic [7:0] RESET_HH   = 8'h06,
  parameter logic [7:0] RESET_MM   = 8'h00,
  parameter int         RING_SEC   = 60,
  parameter int         SNOOZE_MIN = 5
) (
  input  logic      CLK,
  input  logic      RST,
  alarm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_HOUR,
    S_EDIT_MIN,
    S_RING,
    S_SNOOZE
  } state_e;

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);

  localparam logic [RW-1:0] RING_MAX    = RW'(RING_SEC);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_TICKS);

  state_e        state_q, state_d;
  logic [1:0]    ahh_q, ahh_d;
  logic [3:0]    ahl_q, ahl_d;
  logic [2:0]    amh_q, amh_d;
  logic [3:0]    aml_q, aml_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          match_q;
  logic          editing_q, ringing_q, snoozing_q;

  logic          match, trigger;
  logic [1:0]    hr_inc_h;
  logic [3:0]    hr_inc_l;
  logic [2:0]    mn_inc_h;
  logic [3:0]    mn_inc_l;

  // Running time equals alarm time at the top of the minute; fire on the rising edge only
  assign match   = ({bus.HOURH, bus.HOURL} == {ahh_q, ahl_q}) &&
                   ({bus.MINH, bus.MINL} == {amh_q, aml_q}) &&
                   (bus.SECH == 3'd0) && (bus.SECL == 4'd0);
  assign trigger = match & ~match_q & bus.ARM;

  // BCD successors of the alarm hour (wraps 23 -> 00) and minute (wraps 59 -> 00)
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (which would infer a latch).
    hr_inc_h = ahh_q;
    hr_inc_l = ahl_q + 4'd1;
    if (ahh_q == 2'd2 && ahl_q == 4'd3) begin
      hr_inc_h = 2'd0;
      hr_inc_l = 4'd0;
    end else if (ahl_q == 4'd9) begin
      hr_inc_h = ahh_q + 2'd1;
      hr_inc_l = 4'd0;
    end

    mn_inc_h = amh_q;
    mn_inc_l = aml_q + 4'd1;
    if (aml_q == 4'd9) begin
      mn_inc_l = 4'd0;
      mn_inc_h = (amh_q == 3'd5) ? 3'd0 : amh_q + 3'd1;
    end
  end

  // Next-state logic: pulse priority STOP > ALMSET > SELECT > ADJUST among those valid in a state
  always_comb begin
    state_d    = state_q;
    ahh_d      = ahh_q;
    ahl_d      = ahl_q;
    amh_d      = amh_q;
    aml_d      = aml_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d    = S_RING;
          ring_cnt_d = '0;
        end else if (bus.ALMSET) begin
          state_d = S_EDIT_HOUR;
        end
      end

      S_EDIT_HOUR: begin
        if (bus.STOP || bus.ALMSET) begin
          state_d = S_IDLE;
        end else if (bus.SELECT) begin
          state_d = S_EDIT_MIN;
        end else if (bus.ADJUST) begin
          ahh_d = hr_inc_h;
          ahl_d = hr_inc_l;
        end
      end

      S_EDIT_MIN: begin
        if (bus.STOP || bus.ALMSET) begin
          state_d = S_IDLE;
        end else if (bus.SELECT) begin
          state_d = S_EDIT_HOUR;
        end else if (bus.ADJUST) begin
          amh_d = mn_inc_h;
          aml_d = mn_inc_l;
        end
      end

      S_RING: begin
        // Saturating second counter; the last second ends the ring before it could wrap
        if (bus.EN1HZ && ring_cnt_q != RING_MAX) begin
          ring_cnt_d = ring_cnt_q + RW'(1);
        end
        if (bus.STOP || !bus.ARM) begin
          state_d = S_IDLE;
        end else if (bus.EN1HZ && ring_cnt_q == RING_LAST) begin
          state_d = S_IDLE;
        end else if (bus.SELECT) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = SNOOZE_LOAD;
        end
      end

      S_SNOOZE: begin
        if (bus.STOP || !bus.ARM) begin
          state_d = S_IDLE;
        end else if (bus.EN1HZ) begin
          if (snz_cnt_q != '0) begin
            snz_cnt_d = snz_cnt_q - SW'(1);
          end
          if (snz_cnt_q == SW'(1)) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, alarm time, counters, match history and registered status flags
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q    <= S_IDLE;
      ahh_q      <= RESET_HH[5:4];
      ahl_q      <= RESET_HH[3:0];
      amh_q      <= RESET_MM[6:4];
      aml_q      <= RESET_MM[3:0];
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      match_q    <= 1'b1;   // blocks a trigger if the time already matches at release
      editing_q  <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ahh_q      <= ahh_d;
      ahl_q      <= ahl_d;
      amh_q      <= amh_d;
      aml_q      <= aml_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_q    <= match;
      editing_q  <= (state_d == S_EDIT_HOUR) || (state_d == S_EDIT_MIN);
      ringing_q  <= (state_d == S_RING);
      snoozing_q <= (state_d == S_SNOOZE);
    end
  end

  assign bus.AHOURH   = ahh_q;
  assign bus.AHOURL   = ahl_q;
  assign bus.AMINH    = amh_q;
  assign bus.AMINL    = aml_q;
  assign bus.AHOURON  = (state_q == S_EDIT_HOUR) ? bus.SIG2HZ : 1'b1;
  assign bus.AMINON   = (state_q == S_EDIT_MIN)  ? bus.SIG2HZ : 1'b1;
  assign bus.EDITING  = editing_q;
  assign bus.RINGING  = ringing_q;
  assign bus.SNOOZING = snoozing_q;
  assign bus.BUZZ     = ringing_q & bus.SIG2HZ;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed sequences, a table of edit-mode vectors and
// random stimulus, all compared every cycle against a time-of-day level model.
module tb_alarm_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int DAY_SEC    = 86400;

  logic clk;
  logic rst;
  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .RESET_HH  (8'h06),
    .RESET_MM  (8'h00),
    .RING_SEC  (RING_SEC),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (seconds of day, integer alarm time) ----
  typedef enum {M_IDLE, M_EDIT_H, M_EDIT_M, M_RING, M_SNOOZE} mstate_e;

  mstate_e m_state;
  int      m_ah, m_am;      // alarm hour 0..23, minute 0..59
  int      m_rung;          // seconds rung so far
  int      m_snz_left;      // snooze seconds remaining
  bit      m_match_prev;
  int      cur_sec;         // running time of day in seconds

  task automatic drive_time();
    int h, m, s;
    h = cur_sec / 3600;
    m = (cur_sec / 60) % 60;
    s = cur_sec % 60;
    bus.HOURH = 2'(h / 10);
    bus.HOURL = 4'(h % 10);
    bus.MINH  = 3'(m / 10);
    bus.MINL  = 4'(m % 10);
    bus.SECH  = 3'(s / 10);
    bus.SECL  = 4'(s % 10);
  endtask

  task automatic model_edge();
    bit match, trig;
    if (rst) begin
      m_state      = M_IDLE;
      m_ah         = 6;
      m_am         = 0;
      m_rung       = 0;
      m_snz_left   = 0;
      m_match_prev = 1'b1;
      return;
    end
    match = (cur_sec == m_ah * 3600 + m_am * 60);
    trig  = match && !m_match_prev && bus.ARM;
    m_match_prev = match;
    case (m_state)
      M_IDLE: begin
        if (trig) begin m_state = M_RING; m_rung = 0; end
        else if (bus.ALMSET) m_state = M_EDIT_H;
      end
      M_EDIT_H: begin
        if (bus.STOP || bus.ALMSET) m_state = M_IDLE;
        else if (bus.SELECT) m_state = M_EDIT_M;
        else if (bus.ADJUST) m_ah = (m_ah + 1) % 24;
      end
      M_EDIT_M: begin
        if (bus.STOP || bus.ALMSET) m_state = M_IDLE;
        else if (bus.SELECT) m_state = M_EDIT_H;
        else if (bus.ADJUST) m_am = (m_am + 1) % 60;
      end
      M_RING: begin
        if (bus.EN1HZ) m_rung++;
        if (bus.STOP || !bus.ARM) m_state = M_IDLE;
        else if (bus.EN1HZ && m_rung == RING_SEC) m_state = M_IDLE;
        else if (bus.SELECT) begin m_state = M_SNOOZE; m_snz_left = SNOOZE_MIN * 60; end
      end
      M_SNOOZE: begin
        if (bus.STOP || !bus.ARM) m_state = M_IDLE;
        else if (bus.EN1HZ) begin
          m_snz_left--;
          if (m_snz_left == 0) begin m_state = M_RING; m_rung = 0; end
        end
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  function automatic logic [18:0] exp_vec();
    logic hon, mon, ed, rg, sz;
    hon = (m_state == M_EDIT_H) ? bus.SIG2HZ : 1'b1;
    mon = (m_state == M_EDIT_M) ? bus.SIG2HZ : 1'b1;
    ed  = (m_state == M_EDIT_H) || (m_state == M_EDIT_M);
    rg  = (m_state == M_RING);
    sz  = (m_state == M_SNOOZE);
    return {2'(m_ah / 10), 4'(m_ah % 10), 3'(m_am / 10), 4'(m_am % 10),
            hon, mon, ed, rg, sz, rg & bus.SIG2HZ};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.AHOURH, bus.AHOURL, bus.AMINH, bus.AMINL, bus.AHOURON, bus.AMINON,
            bus.EDITING, bus.RINGING, bus.SNOOZING, bus.BUZZ};
  endfunction

  function automatic logic [15:0] dut_alarm();
    return {2'b00, bus.AHOURH, bus.AHOURL, 1'b0, bus.AMINH, bus.AMINL};
  endfunction

  // One clock: model sees the same pre-edge inputs as the DUT, pulses drop after the edge
  task automatic tick();
    bit adv;
    adv = bus.EN1HZ;
    model_edge();
    @(posedge clk);
    #1;
    {bus.ALMSET, bus.SELECT, bus.ADJUST, bus.STOP, bus.EN1HZ} = '0;
    if (adv && !rst) begin
      cur_sec = (cur_sec + 1) % DAY_SEC;
      drive_time();
    end
    check("cycle", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic set_time(input int s);
    cur_sec = s;
    drive_time();
  endtask

  task automatic pulse_en();
    bus.EN1HZ = 1'b1;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Bring the running time up to the alarm so the next cycle rings
  task automatic ring_now();
    set_time((m_ah * 3600 + m_am * 60 + DAY_SEC - 1) % DAY_SEC);
    tick();
    bus.EN1HZ = 1'b1;
    tick();
    tick();
  endtask

  // ---------------- edit-mode vector table ---------------------------------
  typedef struct {
    logic        almset, select, adjust, stop, sig;
    logic        editing;
    logic [15:0] alarm;
    logic        hon, mon;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{0, 1, 0, 0, 0,  0, 16'h0600, 1, 1};
    vecs[1]  = '{0, 0, 1, 0, 0,  0, 16'h0600, 1, 1};
    vecs[2]  = '{1, 0, 0, 0, 0,  1, 16'h0600, 0, 1};
    vecs[3]  = '{0, 0, 1, 0, 1,  1, 16'h0700, 1, 1};
    vecs[4]  = '{0, 0, 1, 0, 0,  1, 16'h0800, 0, 1};
    vecs[5]  = '{0, 0, 1, 0, 0,  1, 16'h0900, 0, 1};
    vecs[6]  = '{0, 0, 1, 0, 0,  1, 16'h1000, 0, 1};
    vecs[7]  = '{0, 1, 1, 0, 0,  1, 16'h1000, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 1,  1, 16'h1001, 1, 1};
    vecs[9]  = '{1, 0, 1, 0, 0,  0, 16'h1001, 1, 1};
    vecs[10] = '{1, 0, 0, 0, 0,  1, 16'h1001, 0, 1};
    vecs[11] = '{1, 0, 0, 1, 0,  0, 16'h1001, 1, 1};
    vecs[12] = '{1, 1, 0, 0, 0,  1, 16'h1001, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 0,  1, 16'h1001, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 0,  1, 16'h1001, 0, 1};
    vecs[15] = '{0, 0, 0, 1, 1,  0, 16'h1001, 1, 1};
  end

  // ---------------- test sequence -------------------------------------------
  initial begin
    {bus.EN1HZ, bus.ALMSET, bus.SELECT, bus.ADJUST, bus.STOP} = '0;
    bus.SIG2HZ = 1'b0;
    bus.ARM    = 1'b1;
    set_time(6 * 3600);

    // Reset while the time already matches the reset alarm
    do_reset();
    repeat (5) tick();
    check("reset_no_ring", 32'(bus.RINGING), 32'd0);
    check("reset_alarm", 32'(dut_alarm()), 32'h0600);
    check("reset_flags", 32'({bus.EDITING, bus.RINGING, bus.SNOOZING, bus.BUZZ,
                              bus.AHOURON, bus.AMINON}), 32'b000011);

    // 05:59:59 -> 06:00:00 rings, buzzer follows SIG2HZ, stops after 60 s
    ring_now();
    check("trigger_ring", 32'(bus.RINGING), 32'd1);
    bus.SIG2HZ = 1'b1; #1;
    check("buzz_high", 32'(bus.BUZZ), 32'd1);
    bus.SIG2HZ = 1'b0; #1;
    check("buzz_low", 32'(bus.BUZZ), 32'd0);
    for (int i = 0; i < RING_SEC - 1; i++) pulse_en();
    check("ring_before_last", 32'(bus.RINGING), 32'd1);
    bus.EN1HZ = 1'b1;
    tick();
    check("ring_autostop", 32'(bus.RINGING), 32'd0);
    tick();

    // Snooze and return to ringing after SNOOZE_MIN*60 seconds
    ring_now();
    bus.SELECT = 1'b1;
    tick();
    check("snooze_enter", 32'({bus.SNOOZING, bus.RINGING}), 32'b10);
    bus.SIG2HZ = 1'b1; #1;
    check("snooze_no_buzz", 32'(bus.BUZZ), 32'd0);
    for (int i = 0; i < SNOOZE_MIN * 60 - 1; i++) pulse_en();
    check("snooze_before_end", 32'(bus.SNOOZING), 32'd1);
    bus.EN1HZ = 1'b1;
    tick();
    check("snooze_rering", 32'({bus.SNOOZING, bus.RINGING}), 32'b01);

    // STOP beats SELECT while ringing
    bus.STOP = 1'b1; bus.SELECT = 1'b1;
    tick();
    check("stop_wins", 32'({bus.SNOOZING, bus.RINGING}), 32'b00);
    tick();

    // A match while editing the minute does not ring
    set_time(5 * 3600 + 59 * 60 + 59);
    tick();
    bus.ALMSET = 1'b1; tick();
    bus.SELECT = 1'b1; tick();
    bus.EN1HZ  = 1'b1; tick();
    repeat (3) tick();
    check("edit_match_no_ring", 32'({bus.EDITING, bus.RINGING}), 32'b10);
    bus.ALMSET = 1'b1; tick();
    repeat (2) tick();
    check("edit_exit_no_ring", 32'({bus.EDITING, bus.RINGING}), 32'b00);

    // Dropping ARM during snooze returns to idle next cycle
    ring_now();
    bus.SELECT = 1'b1; tick();
    check("snooze_again", 32'(bus.SNOOZING), 32'd1);
    bus.ARM = 1'b0; tick();
    check("arm_drop_idle", 32'({bus.SNOOZING, bus.RINGING}), 32'b00);
    bus.ARM = 1'b1;
    tick();

    // Edit: 18 hour steps from 06 wrap to 00, 61 minute steps from 00 reach 01
    bus.ALMSET = 1'b1; tick();
    for (int i = 0; i < 18; i++) begin bus.ADJUST = 1'b1; tick(); end
    check("edit_hour_wrap", 32'({bus.AHOURH, bus.AHOURL}), 32'h00);
    bus.SIG2HZ = 1'b0; #1;
    check("hour_blink", 32'({bus.AHOURON, bus.AMINON}), 32'b01);
    bus.SELECT = 1'b1; tick();
    for (int i = 0; i < 61; i++) begin bus.ADJUST = 1'b1; tick(); end
    check("edit_min_wrap", 32'({bus.AMINH, bus.AMINL}), 32'h01);
    check("min_blink", 32'({bus.AHOURON, bus.AMINON}), 32'b10);
    bus.ALMSET = 1'b1; tick();

    // Vector table from a fresh reset, time well away from the alarm
    bus.ARM = 1'b0;
    set_time(12 * 3600 + 34 * 60 + 56);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      {bus.ALMSET, bus.SELECT, bus.ADJUST, bus.STOP} =
        {vecs[i].almset, vecs[i].select, vecs[i].adjust, vecs[i].stop};
      bus.SIG2HZ = vecs[i].sig;
      tick();
      check($sformatf("vec%0d", i),
            32'({bus.EDITING, dut_alarm(), bus.AHOURON, bus.AMINON}),
            32'({vecs[i].editing, vecs[i].alarm, vecs[i].hon, vecs[i].mon}));
    end

    // Random stimulus against the model
    bus.ARM = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      bus.EN1HZ  = ($urandom_range(0, 3) == 0);
      bus.ALMSET = ($urandom_range(0, 99) == 0);
      bus.SELECT = ($urandom_range(0, 29) == 0);
      bus.ADJUST = ($urandom_range(0, 7) == 0);
      bus.STOP   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 399) == 0) bus.ARM = ~bus.ARM;
      if (c % 25 == 0) bus.SIG2HZ = ~bus.SIG2HZ;
      if ($urandom_range(0, 149) == 0)
        set_time((m_ah * 3600 + m_am * 60 + DAY_SEC - int'($urandom_range(1, 3))) % DAY_SEC);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
